// File: rtl/memory_stage.sv
// Memory stage between execute and write-back: one RV32I load/store transaction
// over a request/ready handshake, single-cycle pass-through for everything else.
//
// state   | meaning
// IDLE    | ready for a new instruction; pass-through results issue from here
// REQUEST | load/store presented to memory, waiting for memoryReadyIn
module memory_stage (
  input  logic             clockIn,
  input  logic             resetIn,
  input  logic             startIn,
  input  logic [31:0]      instructionIn,
  input  logic [31:0]      addressIn,
  input  logic [3:0][31:0] operandsIn,
  input  logic [1:0][31:0] resultsIn,
  output logic [31:0]      memoryAddressOut,
  output logic [31:0]      memoryDataOut,
  output logic [3:0]       memoryByteEnableOut,
  output logic             memoryWriteOut,
  output logic             memoryRequestOut,
  input  logic             memoryReadyIn,
  input  logic [31:0]      memoryDataIn,
  output logic [31:0]      instructionOut,
  output logic [31:0]      addressOut,
  output logic [3:0][31:0] operandsOut,
  output logic [1:0][31:0] resultsOut,
  output logic [31:0]      valueOut,
  output logic             misalignedOut,
  output logic             startOut,
  output logic             readyOut
);

  localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE = 7'b0100011;

  typedef enum logic {IDLE, REQUEST} stateType;

  stateType state, nextState;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] effectiveAddress;
  logic [31:0] storeValue;
  logic        isLoad, isStore, misaligned, memAccess, accept;
  logic [3:0]  laneEnable;
  logic [31:0] laneData;

  logic [2:0]  heldFunct3;
  logic [1:0]  heldOffset;
  logic [7:0]  loadByte;
  logic [15:0] loadHalf;
  logic [31:0] loadValue;

  // Decode of the instruction currently presented on the inputs.
  always_comb begin
    opcode           = instructionIn[6:0];
    funct3           = instructionIn[14:12];
    effectiveAddress = resultsIn[0];
    storeValue       = operandsIn[1];
    isLoad  = (opcode == OPCODE_LOAD) &&
              ((funct3 == 3'd0) || (funct3 == 3'd1) || (funct3 == 3'd2) ||
               (funct3 == 3'd4) || (funct3 == 3'd5));
    isStore = (opcode == OPCODE_STORE) && (funct3 < 3'd3);
    misaligned = (isLoad || isStore) &&
                 (((funct3[1:0] == 2'd1) && effectiveAddress[0]) ||
                  ((funct3[1:0] == 2'd2) && (effectiveAddress[1:0] != 2'b00)));
    memAccess = (isLoad || isStore) && !misaligned;
    accept    = startIn && (state == IDLE);
  end

  always_comb begin
    laneEnable = 4'b1111;
    laneData   = storeValue;
    case (funct3[1:0])
      2'd0: begin
        laneEnable = 4'b0001 << effectiveAddress[1:0];
        laneData   = {4{storeValue[7:0]}};
      end
      2'd1: begin
        laneEnable = 4'b0011 << effectiveAddress[1:0];
        laneData   = {2{storeValue[15:0]}};
      end
      default: begin
        laneEnable = 4'b1111;
        laneData   = storeValue;
      end
    endcase
  end

  // Load extraction uses the registered copies, which stay put during REQUEST.
  always_comb begin
    heldFunct3 = instructionOut[14:12];
    heldOffset = resultsOut[0][1:0];
    loadByte   = memoryDataIn[{heldOffset, 3'b000} +: 8];
    loadHalf   = heldOffset[1] ? memoryDataIn[31:16] : memoryDataIn[15:0];
    case (heldFunct3)
      3'd0:    loadValue = {{24{loadByte[7]}}, loadByte};
      3'd1:    loadValue = {{16{loadHalf[15]}}, loadHalf};
      3'd4:    loadValue = {24'h000000, loadByte};
      3'd5:    loadValue = {16'h0000, loadHalf};
      default: loadValue = memoryDataIn;
    endcase
  end

  always_ff @(posedge clockIn) begin
    if (!resetIn) state <= IDLE;
    else          state <= nextState;
  end

  always_comb begin
    nextState        = state;
    readyOut         = (state == IDLE);
    memoryRequestOut = (state == REQUEST);
    case (state)
      IDLE:    if (accept && memAccess) nextState = REQUEST;
      REQUEST: if (memoryReadyIn)       nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clockIn) begin
    if (!resetIn) begin
      memoryAddressOut    <= '0;
      memoryDataOut       <= '0;
      memoryByteEnableOut <= '0;
      memoryWriteOut      <= 1'b0;
      instructionOut      <= '0;
      addressOut          <= '0;
      operandsOut         <= '0;
      resultsOut          <= '0;
      valueOut            <= '0;
      misalignedOut       <= 1'b0;
      startOut            <= 1'b0;
    end else begin
      startOut <= 1'b0;
      if (accept) begin
        instructionOut <= instructionIn;
        addressOut     <= addressIn;
        operandsOut    <= operandsIn;
        resultsOut     <= resultsIn;
        valueOut       <= '0;
        misalignedOut  <= misaligned;
        startOut       <= !memAccess;
        if (memAccess) begin
          memoryAddressOut    <= {effectiveAddress[31:2], 2'b00};
          memoryDataOut       <= laneData;
          memoryByteEnableOut <= laneEnable;
          memoryWriteOut      <= isStore;
        end
      end else if ((state == REQUEST) && memoryReadyIn) begin
        startOut <= 1'b1;
        valueOut <= memoryWriteOut ? 32'h0 : loadValue;
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: scoreboard of expected write-stage
// results, pushed at issue and popped when startOut pulses.
module tb_memory_stage;

  localparam logic [6:0]  LOAD  = 7'b0000011;
  localparam logic [6:0]  STORE = 7'b0100011;
  localparam logic [31:0] ADD   = 32'h002081B3;

  logic             clockIn = 1'b0;
  logic             resetIn = 1'b0;
  logic             startIn = 1'b0;
  logic [31:0]      instructionIn = '0;
  logic [31:0]      addressIn = '0;
  logic [3:0][31:0] operandsIn = '0;
  logic [1:0][31:0] resultsIn = '0;
  logic [31:0]      memoryAddressOut, memoryDataOut;
  logic [3:0]       memoryByteEnableOut;
  logic             memoryWriteOut, memoryRequestOut;
  logic             memoryReadyIn = 1'b0;
  logic [31:0]      memoryDataIn = '0;
  logic [31:0]      instructionOut, addressOut;
  logic [3:0][31:0] operandsOut;
  logic [1:0][31:0] resultsOut;
  logic [31:0]      valueOut;
  logic             misalignedOut, startOut, readyOut;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] ea;
    logic [31:0] value;
    logic        mis;
  } expType;

  expType sb[$];
  int total = 0;
  int bad = 0;

  always #5 clockIn = ~clockIn;

  memory_stage dut (
    .clockIn(clockIn), .resetIn(resetIn), .startIn(startIn),
    .instructionIn(instructionIn), .addressIn(addressIn),
    .operandsIn(operandsIn), .resultsIn(resultsIn),
    .memoryAddressOut(memoryAddressOut), .memoryDataOut(memoryDataOut),
    .memoryByteEnableOut(memoryByteEnableOut), .memoryWriteOut(memoryWriteOut),
    .memoryRequestOut(memoryRequestOut), .memoryReadyIn(memoryReadyIn),
    .memoryDataIn(memoryDataIn), .instructionOut(instructionOut),
    .addressOut(addressOut), .operandsOut(operandsOut), .resultsOut(resultsOut),
    .valueOut(valueOut), .misalignedOut(misalignedOut), .startOut(startOut),
    .readyOut(readyOut)
  );

  function automatic logic [31:0] mkInstr(input logic [2:0] f3, input logic [6:0] op);
    return {17'h0, f3, 5'h0, op};
  endfunction

  task automatic test_reset();
    resetIn = 1'b0;
    repeat (2) @(negedge clockIn);
    total++; if (readyOut !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", readyOut); end
    total++; if (startOut !== 1'b0) begin bad++; $display("FAIL reset_start got=%b want=0", startOut); end
    total++; if (memoryRequestOut !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", memoryRequestOut); end
    total++; if ({valueOut, instructionOut, memoryByteEnableOut, misalignedOut} !== '0) begin
      bad++; $display("FAIL reset_outputs value=%h instr=%h be=%b mis=%b want all 0",
                      valueOut, instructionOut, memoryByteEnableOut, misalignedOut);
    end
    resetIn = 1'b1;
  endtask

  task automatic test_passthrough();
    expType e;
    @(negedge clockIn);
    instructionIn = ADD; resultsIn[0] = 32'h1234; resultsIn[1] = 32'h77;
    addressIn = 32'h40; startIn = 1'b1; memoryReadyIn = 1'b1;
    e.instr = ADD; e.ea = 32'h1234; e.value = 32'h0; e.mis = 1'b0; sb.push_back(e);
    @(negedge clockIn);
    startIn = 1'b0; memoryReadyIn = 1'b0;
    total++; if (startOut !== 1'b1) begin bad++; $display("FAIL pass_start got=%b want=1", startOut); end
    total++; if (memoryRequestOut !== 1'b0 || readyOut !== 1'b1) begin
      bad++; $display("FAIL pass_handshake req=%b ready=%b want req=0 ready=1", memoryRequestOut, readyOut);
    end
    total++; if (resultsOut[1] !== 32'h77 || addressOut !== 32'h40) begin
      bad++; $display("FAIL pass_copies res1=%h addr=%h want 77/40", resultsOut[1], addressOut);
    end
    if (startOut === 1'b1) begin
      total++;
      if (sb.size() == 0) begin bad++; $display("FAIL pass_sb got=startOut want=empty queue"); end
      else begin
        e = sb.pop_front();
        if (instructionOut !== e.instr || resultsOut[0] !== e.ea || valueOut !== e.value || misalignedOut !== e.mis) begin
          bad++; $display("FAIL pass_result got=%h/%h/%h/%b want=%h/%h/%h/%b", instructionOut, resultsOut[0],
                          valueOut, misalignedOut, e.instr, e.ea, e.value, e.mis);
        end
      end
    end
    @(negedge clockIn);
    total++; if (startOut !== 1'b0) begin bad++; $display("FAIL pass_pulse got=%b want=0", startOut); end
  endtask

  // Includes unsupported load/store funct3 values, which must pass through.
  task automatic test_back_to_back();
    logic [31:0] instrs [3];
    expType e;
    int reqSeen = 0;
    instrs[0] = 32'h40B50533; instrs[1] = mkInstr(3'd3, LOAD); instrs[2] = mkInstr(3'd3, STORE);
    for (int i = 0; i <= 3; i++) begin
      @(negedge clockIn);
      if (memoryRequestOut === 1'b1) reqSeen++;
      if (i > 0) begin
        total++;
        if (startOut !== 1'b1) begin bad++; $display("FAIL b2b_start[%0d] got=%b want=1", i, startOut); end
        else if (sb.size() == 0) begin bad++; $display("FAIL b2b_sb[%0d] got=startOut want=empty queue", i); end
        else begin
          e = sb.pop_front();
          if (instructionOut !== e.instr || resultsOut[0] !== e.ea || valueOut !== e.value || misalignedOut !== e.mis) begin
            bad++; $display("FAIL b2b_result[%0d] got=%h/%h/%h/%b want=%h/%h/%h/%b", i, instructionOut,
                            resultsOut[0], valueOut, misalignedOut, e.instr, e.ea, e.value, e.mis);
          end
        end
      end
      if (i < 3) begin
        instructionIn = instrs[i]; resultsIn[0] = 32'h500 + i; startIn = 1'b1;
        e.instr = instrs[i]; e.ea = 32'h500 + i; e.value = 32'h0; e.mis = 1'b0; sb.push_back(e);
      end else startIn = 1'b0;
    end
    total++; if (reqSeen != 0) begin bad++; $display("FAIL b2b_req got=%0d want=0 request cycles", reqSeen); end
  endtask

  task automatic test_misaligned();
    logic [2:0]  f3s [2];
    logic [31:0] eas [2];
    expType e;
    f3s[0] = 3'd2; eas[0] = 32'h102;
    f3s[1] = 3'd1; eas[1] = 32'h103;
    for (int i = 0; i < 2; i++) begin
      @(negedge clockIn);
      instructionIn = mkInstr(f3s[i], LOAD); resultsIn[0] = eas[i]; startIn = 1'b1;
      e.instr = instructionIn; e.ea = eas[i]; e.value = 32'h0; e.mis = 1'b1; sb.push_back(e);
      @(negedge clockIn);
      startIn = 1'b0;
      total++; if (memoryRequestOut !== 1'b0 || startOut !== 1'b1) begin
        bad++; $display("FAIL mis_timing[%0d] req=%b start=%b want req=0 start=1", i, memoryRequestOut, startOut);
      end
      total++;
      if (sb.size() == 0) begin bad++; $display("FAIL mis_sb[%0d] got=empty queue want=entry", i); end
      else begin
        e = sb.pop_front();
        if (instructionOut !== e.instr || resultsOut[0] !== e.ea || valueOut !== e.value || misalignedOut !== e.mis) begin
          bad++; $display("FAIL mis_result[%0d] got=%h/%h/%h/%b want=%h/%h/%h/%b", i, instructionOut,
                          resultsOut[0], valueOut, misalignedOut, e.instr, e.ea, e.value, e.mis);
        end
      end
    end
  endtask

  task automatic test_mem(input string name, input logic [6:0] op, input logic [2:0] f3,
                          input logic [31:0] ea, input logic [31:0] rs2, input logic [31:0] rdata,
                          input int delay, input logic [3:0] expBe, input logic [31:0] expData,
                          input logic [31:0] expVal);
    expType e;
    logic [31:0] expAddr;
    int reqCycles = 0;
    expAddr = {ea[31:2], 2'b00};
    @(negedge clockIn);
    instructionIn = mkInstr(f3, op); resultsIn[0] = ea; operandsIn[1] = rs2; startIn = 1'b1;
    e.instr = instructionIn; e.ea = ea; e.value = expVal; e.mis = 1'b0; sb.push_back(e);
    @(negedge clockIn);
    startIn = 1'b0; memoryDataIn = 32'hDEAD_BEEF;
    total++; if (readyOut !== 1'b0 || memoryWriteOut !== (op == STORE)) begin
      bad++; $display("FAIL %s ready/write got=%b/%b want=0/%b", name, readyOut, memoryWriteOut, op == STORE);
    end
    for (int i = 1; i <= delay; i++) begin
      if (i > 1) @(negedge clockIn);
      if (memoryRequestOut === 1'b1) reqCycles++;
      total++; if (memoryAddressOut !== expAddr || memoryByteEnableOut !== expBe) begin
        bad++; $display("FAIL %s addr/be cyc%0d got=%h/%b want=%h/%b", name, i, memoryAddressOut,
                        memoryByteEnableOut, expAddr, expBe);
      end
      if (op == STORE) begin
        total++; if (memoryDataOut !== expData) begin
          bad++; $display("FAIL %s data got=%h want=%h", name, memoryDataOut, expData);
        end
      end
      if (i == delay) begin memoryReadyIn = 1'b1; memoryDataIn = rdata; end
    end
    @(negedge clockIn);
    memoryReadyIn = 1'b0; memoryDataIn = 32'hDEAD_BEEF;
    total++; if (reqCycles != delay) begin bad++; $display("FAIL %s req_cycles got=%0d want=%0d", name, reqCycles, delay); end
    total++; if (startOut !== 1'b1 || memoryRequestOut !== 1'b0 || readyOut !== 1'b1) begin
      bad++; $display("FAIL %s completion start=%b req=%b ready=%b want 1/0/1", name, startOut, memoryRequestOut, readyOut);
    end
    if (startOut === 1'b1) begin
      total++;
      if (sb.size() == 0) begin bad++; $display("FAIL %s sb got=startOut want=empty queue", name); end
      else begin
        e = sb.pop_front();
        if (instructionOut !== e.instr || resultsOut[0] !== e.ea || valueOut !== e.value || misalignedOut !== e.mis) begin
          bad++; $display("FAIL %s result got=%h/%h/%h/%b want=%h/%h/%h/%b", name, instructionOut,
                          resultsOut[0], valueOut, misalignedOut, e.instr, e.ea, e.value, e.mis);
        end
      end
    end
    @(negedge clockIn);
    total++; if (startOut !== 1'b0 || valueOut !== expVal) begin
      bad++; $display("FAIL %s hold start=%b value=%h want 0/%h", name, startOut, valueOut, expVal);
    end
  endtask

  task automatic test_reset_mid_request();
    int starts = 0;
    @(negedge clockIn);
    instructionIn = mkInstr(3'd2, LOAD); resultsIn[0] = 32'h100; startIn = 1'b1;
    @(negedge clockIn);
    startIn = 1'b0;
    total++; if (memoryRequestOut !== 1'b1) begin bad++; $display("FAIL rst_req_before got=%b want=1", memoryRequestOut); end
    resetIn = 1'b0; memoryReadyIn = 1'b1; memoryDataIn = 32'h1111_2222;
    @(negedge clockIn);
    resetIn = 1'b1; memoryReadyIn = 1'b0;
    total++; if (memoryRequestOut !== 1'b0 || readyOut !== 1'b1) begin
      bad++; $display("FAIL rst_abandon req=%b ready=%b want 0/1", memoryRequestOut, readyOut);
    end
    if (startOut === 1'b1) starts++;
    repeat (2) begin
      @(negedge clockIn);
      if (startOut === 1'b1) starts++;
    end
    total++; if (starts != 0) begin bad++; $display("FAIL rst_no_start got=%0d want=0 pulses", starts); end
    test_mem("lw_after_reset", LOAD, 3'd2, 32'h300, 32'h0, 32'h1234_5678, 2, 4'b1111, 32'h0, 32'h1234_5678);
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_back_to_back();
    test_mem("lb",  LOAD, 3'd0, 32'h103, 32'h0, 32'h80FF_FF7F, 3, 4'b1000, 32'h0, 32'hFFFF_FF80);
    test_mem("lbu", LOAD, 3'd4, 32'h103, 32'h0, 32'h80FF_FF7F, 3, 4'b1000, 32'h0, 32'h0000_0080);
    test_mem("lh",  LOAD, 3'd1, 32'h102, 32'h0, 32'h8001_1234, 1, 4'b1100, 32'h0, 32'hFFFF_8001);
    test_mem("lhu", LOAD, 3'd5, 32'h102, 32'h0, 32'h8001_1234, 2, 4'b1100, 32'h0, 32'h0000_8001);
    test_mem("lb0", LOAD, 3'd0, 32'h100, 32'h0, 32'h80FF_FF7F, 1, 4'b0001, 32'h0, 32'h0000_007F);
    test_mem("sb",  STORE, 3'd0, 32'h201, 32'hAABB_CCDD, 32'h0, 1, 4'b0010, 32'hDDDD_DDDD, 32'h0);
    test_mem("sh",  STORE, 3'd1, 32'h202, 32'hAABB_CCDD, 32'h0, 2, 4'b1100, 32'hCCDD_CCDD, 32'h0);
    test_mem("sw",  STORE, 3'd2, 32'h200, 32'hAABB_CCDD, 32'h0, 1, 4'b1111, 32'hAABB_CCDD, 32'h0);
    test_misaligned();
    test_reset_mid_request();
    total++; if (sb.size() != 0) begin bad++; $display("FAIL sb_drain got=%0d want=0 pending", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
